cp0_exc_ctrl: RTL and testbench

//  Parametrised coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId plus Count/Compare timer.

---
 rtl/cp0_pkg.sv | 21 ++
 rtl/cp0_exc_ctrl_if.sv | 11 +
 rtl/cp0_timer.sv | 42 ++++
 rtl/cp0_exc_ctrl.sv | 117 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, ExcCode constants and PC alignment helper
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - mfc0/mtc0 register access bus between core and CP0
interface cp0_exc_ctrl_if;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare registers with sticky timer-pending flag
module cp0_timer #(
  parameter bit TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  logic [31:0] count_next;

  // A software load replaces the increment for that cycle; wrap is silent.
  always_comb begin
    count_next = count;
    if (count_we)
      count_next = wr_data;
    else if (TIMER_EN)
      count_next = count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 32'd0;
      compare    <= 32'hFFFF_FFFF;
      timer_pend <= 1'b0;
    end else begin
      count <= count_next;
      if (compare_we)
        compare <= wr_data;
      if (compare_we)
        timer_pend <= 1'b0;
      else if (TIMER_EN && (count_next == compare))
        timer_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 SR/Cause/EPC/PRId, interrupt latching and exception arbitration
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000000,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID_VAL  = 32'h0000_2021,
  parameter logic [31:0] RESET_EPC = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 reset,
  cp0_exc_ctrl_if.slave        bus,
  input  logic [31:0]          pc_m,
  input  logic                 bd_m,
  input  logic                 exc_valid_m,
  input  logic [4:0]           exc_code_m,
  input  logic                 eret_m,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic                 take,
  output logic                 exl_o,
  output logic [31:0]          epc_o
);

  localparam logic [NUM_HWINT-1:0] EDGE = EDGE_MASK[NUM_HWINT-1:0];

  logic                 ie, exl, bd;
  logic [4:0]           exc_code;
  logic [31:0]          epc;
  logic [NUM_HWINT-1:0] im, ip, ip_next, ip_keep, raw, hw_q, hw_qq;
  logic [5:0]           im6, ip6;
  logic [31:0]          count, compare;
  logic                 timer_pend, int_req;
  logic                 wr_sr, wr_cause, wr_epc;

  assign wr_sr    = bus.wr_en && (bus.wr_addr == CP0_SR);
  assign wr_cause = bus.wr_en && (bus.wr_addr == CP0_CAUSE);
  assign wr_epc   = bus.wr_en && (bus.wr_addr == CP0_EPC);

  cp0_timer #(.TIMER_EN(TIMER_EN)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (bus.wr_en && (bus.wr_addr == CP0_COUNT)),
    .compare_we (bus.wr_en && (bus.wr_addr == CP0_COMPARE)),
    .wr_data    (bus.wr_data),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );

  // Edge lines detect a rise between the sample stage and its delayed copy, so
  // they see one cycle more latency than level lines.
  always_comb begin
    raw                = hw_int;
    raw[NUM_HWINT-1]   = hw_int[NUM_HWINT-1] | timer_pend;
    ip_keep            = wr_cause ? bus.wr_data[10 +: NUM_HWINT] : {NUM_HWINT{1'b1}};
    ip_next            = (EDGE & ((hw_q & ~hw_qq) | (ip & ip_keep))) | (~EDGE & raw);
    im6                = 6'd0;
    im6[NUM_HWINT-1:0] = im;
    ip6                = 6'd0;
    ip6[NUM_HWINT-1:0] = ip;
  end

  assign int_req = (|(ip & im)) & ie & ~exl;
  assign take    = exc_valid_m | int_req;
  assign exl_o   = exl;
  assign epc_o   = epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      ip       <= '0;
      hw_q     <= '0;
      hw_qq    <= '0;
      bd       <= 1'b0;
      exc_code <= EXC_INT;
      epc      <= RESET_EPC;
    end else begin
      hw_q  <= raw;
      hw_qq <= hw_q;
      ip    <= ip_next;
      if (wr_sr) begin
        im <= bus.wr_data[10 +: NUM_HWINT];
        ie <= bus.wr_data[0];
      end
      if (take) begin
        exl      <= 1'b1;
        exc_code <= exc_valid_m ? exc_code_m : EXC_INT;
      end else if (eret_m)
        exl <= 1'b0;
      else if (wr_sr)
        exl <= bus.wr_data[1];
      // EPC/BD are frozen while a handler is already running (nested exception).
      if (take && !exl) begin
        epc <= bd_m ? word_align(pc_m) - 32'd4 : word_align(pc_m);
        bd  <= bd_m;
      end else if (wr_epc)
        epc <= word_align(bus.wr_data);
    end
  end

  always_comb begin
    bus.rd_data = 32'd0;
    case (bus.rd_addr)
      CP0_COUNT:   bus.rd_data = count;
      CP0_COMPARE: bus.rd_data = compare;
      CP0_SR:      bus.rd_data = {16'd0, im6, 8'd0, exl, ie};
      CP0_CAUSE:   bus.rd_data = {bd, 15'd0, ip6, 3'd0, exc_code, 2'd0};
      CP0_EPC:     bus.rd_data = epc;
      CP0_PRID:    bus.rd_data = PRID_VAL;
      default:     bus.rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m, exc_valid_m, eret_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        take, exl_o;
  logic [31:0] epc_o;
  logic [31:0] d;
  int          n_checks = 0;
  int          n_fails  = 0;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(
    .NUM_HWINT (6),
    .EDGE_MASK (6'b000010),
    .TIMER_EN  (1'b1),
    .PRID_VAL  (32'h0000_2021),
    .RESET_EPC (32'h0000_3000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .pc_m        (pc_m),
    .bd_m        (bd_m),
    .exc_valid_m (exc_valid_m),
    .exc_code_m  (exc_code_m),
    .eret_m      (eret_m),
    .hw_int      (hw_int),
    .take        (take),
    .exl_o       (exl_o),
    .epc_o       (epc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = v;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] v);
    bus.rd_addr = a;
    #1;
    v = bus.rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mfc0(CP0_SR, d);
    n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL reset_sr got %h want %h", d, 32'h0); end
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL reset_cause got %h want %h", d, 32'h0); end
    mfc0(CP0_EPC, d);
    n_checks++; if (d !== 32'h3000) begin n_fails++; $display("FAIL reset_epc got %h want %h", d, 32'h3000); end
    mfc0(CP0_PRID, d);
    n_checks++; if (d !== 32'h2021) begin n_fails++; $display("FAIL reset_prid got %h want %h", d, 32'h2021); end
    mfc0(CP0_COMPARE, d);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL reset_compare got %h want %h", d, 32'hFFFF_FFFF); end
    mfc0(CP0_COUNT, d);
    n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL reset_count got %h want %h", d, 32'h0); end
    mfc0(5'd20, d);
    n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL unmapped_read got %h want %h", d, 32'h0); end
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL reset_take got %b want 0", take); end
    n_checks++; if (exl_o !== 1'b0) begin n_fails++; $display("FAIL reset_exl got %b want 0", exl_o); end
    n_checks++; if (epc_o !== 32'h3000) begin n_fails++; $display("FAIL reset_epc_o got %h want %h", epc_o, 32'h3000); end
  endtask

  task automatic test_level_irq();
    mtc0(CP0_SR, 32'h0000_0401);
    pc_m   = 32'h3010;
    hw_int = 6'b000001;
    #1;
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL level_take_early got %b want 0", take); end
    tick();
    n_checks++; if (take !== 1'b1) begin n_fails++; $display("FAIL level_take got %b want 1", take); end
    tick();
    n_checks++; if (exl_o !== 1'b1) begin n_fails++; $display("FAIL level_exl got %b want 1", exl_o); end
    n_checks++; if (epc_o !== 32'h3010) begin n_fails++; $display("FAIL level_epc got %h want %h", epc_o, 32'h3010); end
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d !== 32'h0000_0400) begin n_fails++; $display("FAIL level_cause got %h want %h", d, 32'h400); end
    mfc0(CP0_SR, d);
    n_checks++; if (d !== 32'h0000_0403) begin n_fails++; $display("FAIL level_sr got %h want %h", d, 32'h403); end
    hw_int = 6'b0;
  endtask

  task automatic test_exc_priority();
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    n_checks++; if (exl_o !== 1'b0) begin n_fails++; $display("FAIL eret_exl got %b want 0", exl_o); end
    hw_int = 6'b000001;
    tick();
    exc_valid_m = 1'b1; exc_code_m = EXC_OV; pc_m = 32'h3024; bd_m = 1'b1;
    #1;
    n_checks++; if (take !== 1'b1) begin n_fails++; $display("FAIL exc_take got %b want 1", take); end
    tick();
    exc_valid_m = 1'b0; bd_m = 1'b0;
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d !== 32'h8000_0430) begin n_fails++; $display("FAIL exc_cause got %h want %h", d, 32'h8000_0430); end
    n_checks++; if (epc_o !== 32'h3020) begin n_fails++; $display("FAIL exc_bd_epc got %h want %h", epc_o, 32'h3020); end
    hw_int = 6'b0;
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    n_checks++; if (exl_o !== 1'b0) begin n_fails++; $display("FAIL exc_eret_exl got %b want 0", exl_o); end
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL exc_idle_take got %b want 0", take); end
  endtask

  task automatic test_nested();
    exc_valid_m = 1'b1; exc_code_m = EXC_ADEL; pc_m = 32'h4000;
    tick();
    exc_code_m = EXC_RI; pc_m = 32'h4180;
    #1;
    n_checks++; if (take !== 1'b1) begin n_fails++; $display("FAIL nested_take got %b want 1", take); end
    tick();
    exc_valid_m = 1'b0;
    n_checks++; if (epc_o !== 32'h4000) begin n_fails++; $display("FAIL nested_epc got %h want %h", epc_o, 32'h4000); end
    n_checks++; if (exl_o !== 1'b1) begin n_fails++; $display("FAIL nested_exl got %b want 1", exl_o); end
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d !== 32'h0000_0028) begin n_fails++; $display("FAIL nested_cause got %h want %h", d, 32'h28); end
    hw_int = 6'b000001;
    tick();
    tick();
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL nested_irq_masked got %b want 0", take); end
    hw_int = 6'b0;
    tick();
    mtc0(CP0_EPC, 32'h0000_5007);
    n_checks++; if (epc_o !== 32'h5004) begin n_fails++; $display("FAIL epc_write_align got %h want %h", epc_o, 32'h5004); end
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
  endtask

  task automatic test_edge_irq();
    mtc0(CP0_SR, 32'h0000_0401);
    hw_int = 6'b000010;
    tick();
    hw_int = 6'b0;
    tick();
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d[15:10] !== 6'b000010) begin n_fails++; $display("FAIL edge_ip_set got %b want %b", d[15:10], 6'b000010); end
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL edge_masked_take got %b want 0", take); end
    tick();
    tick();
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d[15:10] !== 6'b000010) begin n_fails++; $display("FAIL edge_ip_held got %b want %b", d[15:10], 6'b000010); end
    mtc0(CP0_SR, 32'h0000_0C01);
    n_checks++; if (take !== 1'b1) begin n_fails++; $display("FAIL edge_take got %b want 1", take); end
    pc_m = 32'h3100;
    tick();
    n_checks++; if (epc_o !== 32'h3100) begin n_fails++; $display("FAIL edge_epc got %h want %h", epc_o, 32'h3100); end
    mtc0(CP0_CAUSE, 32'h0);
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d !== 32'h0) begin n_fails++; $display("FAIL edge_ip_clear got %h want %h", d, 32'h0); end
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
  endtask

  task automatic test_timer();
    mtc0(CP0_SR, 32'h0000_8001);
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    mfc0(CP0_COUNT, d);
    n_checks++; if (d !== 32'd5) begin n_fails++; $display("FAIL timer_count got %0d want 5", d); end
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL timer_take_early got %b want 0", take); end
    tick();
    n_checks++; if (take !== 1'b1) begin n_fails++; $display("FAIL timer_take got %b want 1", take); end
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d[15] !== 1'b1) begin n_fails++; $display("FAIL timer_ip got %b want 1", d[15]); end
    mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
    tick();
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d[15] !== 1'b0) begin n_fails++; $display("FAIL timer_ip_clear got %b want 0", d[15]); end
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    n_checks++; if (take !== 1'b0) begin n_fails++; $display("FAIL timer_quiet got %b want 0", take); end
  endtask

  task automatic test_same_cycle();
    exc_valid_m = 1'b1; exc_code_m = EXC_ADES; pc_m = 32'h6000; eret_m = 1'b1;
    mtc0(CP0_EPC, 32'h7000);
    exc_valid_m = 1'b0; eret_m = 1'b0;
    n_checks++; if (exl_o !== 1'b1) begin n_fails++; $display("FAIL same_exl got %b want 1", exl_o); end
    n_checks++; if (epc_o !== 32'h6000) begin n_fails++; $display("FAIL same_epc got %h want %h", epc_o, 32'h6000); end
    mfc0(CP0_CAUSE, d);
    n_checks++; if (d[6:2] !== EXC_ADES) begin n_fails++; $display("FAIL same_code got %0d want %0d", d[6:2], EXC_ADES); end
  endtask

  initial begin
    reset = 1'b1; pc_m = 32'h0; bd_m = 1'b0; exc_valid_m = 1'b0; exc_code_m = 5'd0;
    eret_m = 1'b0; hw_int = 6'b0;
    bus.rd_addr = 5'd0; bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'h0;
    test_reset();
    test_level_irq();
    test_exc_priority();
    test_nested();
    test_edge_irq();
    test_timer();
    test_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
